// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32I pipeline: forwarding selects, hazard FSM
// state and the decoder opcode constants.
package pipeline_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ    = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TRAP     = 2'd2
    } hazState_t;

    // Registered FSM view; kept as one struct so the state is easy to probe.
    typedef struct packed {
        hazState_t state;
        logic      timeoutErr;
    } hazFsm_t;

    // The younger producer in M wins over the one in W; x0 never forwards.
    function automatic logic [1:0] fwdSel(
        input logic       regWriteM,
        input logic [4:0] rdM,
        input logic       regWriteW,
        input logic [4:0] rdW,
        input logic [4:0] rs
    );
        if (regWriteM && (rdM != 5'd0) && (rdM == rs)) begin
            return FWD_M;
        end else if (regWriteW && (rdW != 5'd0) && (rdW == rs)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: forwarding, load-use
// interlock, data-memory wait FSM with timeout trap and event counters.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int XLEN_CNT    = 32,
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          Rs1D,
    input  logic [4:0]          Rs2D,
    input  logic [4:0]          Rs1E,
    input  logic [4:0]          Rs2E,
    input  logic [4:0]          RdE,
    input  logic [4:0]          RdM,
    input  logic [4:0]          RdW,
    input  logic                RegWriteM,
    input  logic                RegWriteW,
    input  logic                ResultSrcE0,
    input  logic                PCSrcE,
    input  logic                MemReqM,
    input  logic                dmem_ready,
    output logic                StallF,
    output logic                StallD,
    output logic                StallE,
    output logic                StallM,
    output logic                FlushD,
    output logic                FlushE,
    output logic                FlushW,
    output logic [1:0]          ForwardAE,
    output logic [1:0]          ForwardBE,
    output logic                mem_timeout_err,
    output logic [XLEN_CNT-1:0] stall_cnt,
    output logic [XLEN_CNT-1:0] flush_cnt
);

    hazFsm_t         fsm;
    hazFsm_t         fsmNext;
    logic [TO_W-1:0] waitCnt;
    logic [TO_W-1:0] waitCntNext;
    logic            memStall;
    logic            lwStall;
    logic            holdAll;

    assign ForwardAE = fwdSel(RegWriteM, RdM, RegWriteW, RdW, Rs1E);
    assign ForwardBE = fwdSel(RegWriteM, RdM, RegWriteW, RdW, Rs2E);

    // A taken branch squashes the dependent instruction, so no interlock.
    assign lwStall  = ResultSrcE0 && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;
    assign memStall = MemReqM && !dmem_ready;

    assign mem_timeout_err = fsm.timeoutErr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm     <= '{state: ST_RUN, timeoutErr: 1'b0};
            waitCnt <= '0;
        end else begin
            fsm     <= fsmNext;
            waitCnt <= waitCntNext;
        end
    end

    always_comb begin
        fsmNext     = fsm;
        waitCntNext = waitCnt;
        unique case (fsm.state)
            ST_RUN: begin
                if (memStall) begin
                    fsmNext.state = ST_MEM_WAIT;
                    waitCntNext   = TO_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (!memStall) begin
                    fsmNext.state = ST_RUN;
                    waitCntNext   = '0;
                end else if (waitCnt == TO_W'(MEM_TIMEOUT)) begin
                    fsmNext.state      = ST_TRAP;
                    fsmNext.timeoutErr = 1'b1;
                end else begin
                    waitCntNext = waitCnt + 1'b1;
                end
            end
            ST_TRAP: begin
                fsmNext = fsm;
            end
            default: begin
                fsmNext.state = ST_RUN;
                waitCntNext   = '0;
            end
        endcase

        // Freezing the whole pipe hides PCSrcE; E is held so it resolves again on release.
        holdAll = (fsm.state == ST_TRAP) || memStall;
        if (holdAll) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushW = 1'b1;
        end else begin
            StallF = lwStall;
            StallD = lwStall;
            StallE = 1'b0;
            StallM = 1'b0;
            FlushD = PCSrcE;
            FlushE = lwStall || PCSrcE;
            FlushW = 1'b0;
        end
    end

    sat_counter #(.WIDTH(XLEN_CNT)) uStallCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (StallF),
        .clear (1'b0),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(XLEN_CNT)) uFlushCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (FlushE),
        .clear (1'b0),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; expected output vectors are
// queued by the driver and checked by a negedge monitor.
module tb_pipeline_hazard_ctrl;

    localparam int CW = 4;

    // stall nibble {F,D,E,M}, flush triple {D,E,W}
    localparam logic [3:0] S_NONE = 4'b0000;
    localparam logic [3:0] S_FD   = 4'b1100;
    localparam logic [3:0] S_ALL  = 4'b1111;
    localparam logic [2:0] F_NONE = 3'b000;
    localparam logic [2:0] F_E    = 3'b010;
    localparam logic [2:0] F_DE   = 3'b110;
    localparam logic [2:0] F_W    = 3'b001;

    logic          clk;
    logic          rst;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, dmem_ready;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          mem_timeout_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    logic [19:0]   obs;
    logic [19:0]   expQ[$];
    string         nameQ[$];
    logic [19:0]   monExp;
    string         monName;
    int            testsRun = 0;
    int            testsFailed = 0;

    pipeline_hazard_ctrl #(.XLEN_CNT(CW), .MEM_TIMEOUT(4), .TO_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .Rs1D            (Rs1D),
        .Rs2D            (Rs2D),
        .Rs1E            (Rs1E),
        .Rs2E            (Rs2E),
        .RdE             (RdE),
        .RdM             (RdM),
        .RdW             (RdW),
        .RegWriteM       (RegWriteM),
        .RegWriteW       (RegWriteW),
        .ResultSrcE0     (ResultSrcE0),
        .PCSrcE          (PCSrcE),
        .MemReqM         (MemReqM),
        .dmem_ready      (dmem_ready),
        .StallF          (StallF),
        .StallD          (StallD),
        .StallE          (StallE),
        .StallM          (StallM),
        .FlushD          (FlushD),
        .FlushE          (FlushE),
        .FlushW          (FlushW),
        .ForwardAE       (ForwardAE),
        .ForwardBE       (ForwardBE),
        .mem_timeout_err (mem_timeout_err),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                  ForwardAE, ForwardBE, mem_timeout_err, stall_cnt, flush_cnt};

    function automatic logic [19:0] mk(input logic [3:0] st, input logic [2:0] fl,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic err, input logic [3:0] sc,
                                       input logic [3:0] fc);
        return {st, fl, fa, fb, err, sc, fc};
    endfunction

    // driver tasks
    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0;
        MemReqM = 0; dmem_ready = 0;
    endtask

    task automatic step(input string nm, input logic [19:0] e);
        expQ.push_back(e);
        nameQ.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic setLoadUse();
        ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (expQ.size() != 0) begin
            monExp  = expQ.pop_front();
            monName = nameQ.pop_front();
            testsRun++;
            if (obs !== monExp) begin
                testsFailed++;
                $display("FAIL %s: got %h expected %h", monName, obs, monExp);
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        step("reset", 20'h0);
        rst = 1'b0;

        // forwarding
        RdM = 5; RegWriteM = 1; Rs1E = 5; RdW = 5; RegWriteW = 1;
        step("fwdA_Mprio", mk(S_NONE, F_NONE, 2'b10, 2'b00, 0, 0, 0));
        RdM = 0;
        step("fwdA_rdM0", mk(S_NONE, F_NONE, 2'b01, 2'b00, 0, 0, 0));
        idle(); Rs1E = 3; Rs2E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        step("fwdB_Mprio", mk(S_NONE, F_NONE, 2'b00, 2'b10, 0, 0, 0));
        RegWriteM = 0;
        step("fwdB_W", mk(S_NONE, F_NONE, 2'b00, 2'b01, 0, 0, 0));
        RdW = 0;
        step("fwdB_rdW0", mk(S_NONE, F_NONE, 2'b00, 2'b00, 0, 0, 0));
        idle(); Rs1E = 9; Rs2E = 9; RdM = 9; RdW = 9; RegWriteW = 1;
        step("fwdAB_W", mk(S_NONE, F_NONE, 2'b01, 2'b01, 0, 0, 0));

        // load-use
        idle(); setLoadUse();
        step("lwStall", mk(S_FD, F_E, 0, 0, 0, 0, 0));
        idle();
        step("lwRelease", mk(S_NONE, F_NONE, 0, 0, 0, 1, 1));
        setLoadUse(); PCSrcE = 1;
        step("lwBranch", mk(S_NONE, F_DE, 0, 0, 0, 1, 1));
        idle();
        step("lwBranchAfter", mk(S_NONE, F_NONE, 0, 0, 0, 1, 2));
        ResultSrcE0 = 1; RdE = 0;
        step("lwRdE0", mk(S_NONE, F_NONE, 0, 0, 0, 1, 2));
        idle(); RdE = 7; Rs2D = 7;
        step("noLoad", mk(S_NONE, F_NONE, 0, 0, 0, 1, 2));
        idle(); ResultSrcE0 = 1; RdE = 3; Rs1D = 3;
        step("lwRs1", mk(S_FD, F_E, 0, 0, 0, 1, 2));
        idle();
        step("lwRs1After", mk(S_NONE, F_NONE, 0, 0, 0, 2, 3));

        // memory wait of 3 cycles, then 4 cycles (stays below timeout if wait_cnt cleared)
        doReset();
        MemReqM = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) step("memWait3", mk(S_ALL, F_W, 0, 0, 0, 4'(i), 0));
        dmem_ready = 1;
        step("memDone3", mk(S_NONE, F_NONE, 0, 0, 0, 3, 0));
        dmem_ready = 0;
        for (int i = 0; i < 4; i++) step("memWait4", mk(S_ALL, F_W, 0, 0, 0, 4'(3 + i), 0));
        dmem_ready = 1;
        step("memDone4", mk(S_NONE, F_NONE, 0, 0, 0, 7, 0));
        idle();
        step("memIdle", mk(S_NONE, F_NONE, 0, 0, 0, 7, 0));

        // branch and load-use under memory stall
        doReset();
        MemReqM = 1; dmem_ready = 0; PCSrcE = 1; setLoadUse();
        step("brUnderStall1", mk(S_ALL, F_W, 0, 0, 0, 0, 0));
        step("brUnderStall2", mk(S_ALL, F_W, 0, 0, 0, 1, 0));
        dmem_ready = 1;
        step("brRelease", mk(S_NONE, F_DE, 0, 0, 0, 2, 0));
        idle();
        step("brFlushCnt", mk(S_NONE, F_NONE, 0, 0, 0, 2, 1));

        // timeout trap
        doReset();
        MemReqM = 1; dmem_ready = 0;
        for (int i = 0; i < 5; i++) step("toWait", mk(S_ALL, F_W, 0, 0, 0, 4'(i), 0));
        step("toTrapErr", mk(S_ALL, F_W, 0, 0, 1, 5, 0));
        idle();
        step("trapIdle", mk(S_ALL, F_W, 0, 0, 1, 6, 0));
        MemReqM = 1; dmem_ready = 1; PCSrcE = 1;
        step("trapBranch", mk(S_ALL, F_W, 0, 0, 1, 7, 0));
        rst = 1'b1; idle();
        step("rstInTrap", 20'h0);
        rst = 1'b0;
        step("afterTrapRst", 20'h0);

        // counter saturation, then async reset mid-wait
        doReset();
        setLoadUse();
        for (int i = 0; i < 20; i++) begin
            logic [3:0] v;
            v = (i > 15) ? 4'd15 : 4'(i);
            step("satLw", mk(S_FD, F_E, 0, 0, 0, v, v));
        end
        idle();
        step("satHold", mk(S_NONE, F_NONE, 0, 0, 0, 15, 15));
        MemReqM = 1; dmem_ready = 0;
        step("satMem1", mk(S_ALL, F_W, 0, 0, 0, 15, 15));
        step("satMem2", mk(S_ALL, F_W, 0, 0, 0, 15, 15));
        rst = 1'b1; idle();
        step("rstMidWait", 20'h0);
        rst = 1'b0;
        step("afterWaitRst", 20'h0);

        // final report
        @(posedge clk);
        #1;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard and stall controller for the 5-stage RV32I pipeline (F/D/E/M/W).
- Generates stall, flush and forwarding controls from register addresses, the control signals produced by the main decoder (RegWrite, ResultSrc, Jump/Branch outcome), and a data-memory ready handshake.
- Owns a data-memory wait FSM with timeout detection, plus saturating stall/flush performance counters.
- Sits beside the pipeline registers. Its outputs drive their enable and clear inputs.

Parameters:
- XLEN_CNT, 32, width of each performance counter.
- MEM_TIMEOUT, 255, maximum consecutive dmem wait cycles before the error trap (1..2^16-1).
- TO_W, 16, width of the wait-cycle counter; must satisfy MEM_TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- Rs1D, Rs2D  in  5  source registers in Decode
- Rs1E, Rs2E, RdE  in  5  source and destination registers in Execute
- RdM, RdW  in  5  destination registers in Memory and Writeback
- RegWriteM, RegWriteW  in  1  writeback enables in M and W
- ResultSrcE0  in  1  bit 0 of ResultSrc in Execute (1 = load in E)
- PCSrcE  in  1  taken branch or jump resolved in E
- MemReqM  in  1  load or store active in M
- dmem_ready  in  1  data memory completes the access this cycle
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushD, FlushE, FlushW  out  1  clear the register to a bubble
- ForwardAE, ForwardBE  out  2  00 = register file, 10 = ALUResultM, 01 = ResultW
- mem_timeout_err  out  1  sticky dmem timeout flag
- stall_cnt, flush_cnt  out  XLEN_CNT  saturating event counters

Behaviour:
- Reset:
  - Asynchronous on rst. State = RUN; wait_cnt = 0; counters = 0; mem_timeout_err = 0.
  - All stall and flush outputs are 0 while the state is RUN with idle inputs.
- Forwarding (combinational, zero latency):
  - ForwardAE = 10 if RegWriteM & RdM != 0 & RdM == Rs1E.
  - Else 01 if RegWriteW & RdW != 0 & RdW == Rs1E.
  - Else 00. M priority over W. ForwardBE is identical using Rs2E.
- Load-use:
  - lwStall = ResultSrcE0 & RdE != 0 & (RdE == Rs1D | RdE == Rs2D) & ~PCSrcE.
  - A taken branch squashes the dependent instruction, so no stall is taken.
- mem_stall = MemReqM & ~dmem_ready (combinational, every state).
- FSM states: RUN, MEM_WAIT, TRAP.
  - RUN -> MEM_WAIT when mem_stall. wait_cnt <= 1.
  - MEM_WAIT stays while mem_stall; wait_cnt increments.
  - MEM_WAIT -> RUN when dmem_ready or ~MemReqM. wait_cnt <= 0.
  - MEM_WAIT -> TRAP when mem_stall and wait_cnt == MEM_TIMEOUT. mem_timeout_err <= 1.
  - TRAP is absorbing until rst. In TRAP: StallF/D/E/M = 1, FlushW = 1, FlushD = FlushE = 0.
- Output priority, applied in order:
  1. TRAP or mem_stall: StallF = StallD = StallE = StallM = 1, FlushW = 1, FlushD = FlushE = 0. This overrides lwStall and PCSrcE; PCSrcE is re-evaluated after release because E is held.
  2. Otherwise:
     - StallF = StallD = lwStall, StallE = StallM = 0, FlushW = 0.
     - FlushD = PCSrcE.
     - FlushE = lwStall | PCSrcE.
- Counters (registered, update on clk):
  - stall_cnt += 1 in any cycle where StallF = 1.
  - flush_cnt += 1 in any cycle where FlushE = 1.
  - Both saturate at all-ones and never wrap.
- Reset mid-wait: immediately returns to RUN. Any outstanding dmem access is the memory's responsibility.
- MemReqM dropping during MEM_WAIT, which is illegal upstream, returns the FSM to RUN with no error.

Decomposition:
- Shared package `pipeline_pkg`:
  - Encodings FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
  - FSM state encodings.
  - Opcode constants already used by the decoder (lw, sw, R_type, beq, jal, jalr, imm).
- One natural sub-module, `sat_counter`, parameterised by width with inc and clear inputs; instantiated twice.

Test Plan:
- RAW via M: RdM = 5, RegWriteM = 1, Rs1E = 5, RdW = 5, RegWriteW = 1 -> ForwardAE = 10 (M priority). With RdM = 0 instead -> ForwardAE = 01.
- Load-use: ResultSrcE0 = 1, RdE = 7, Rs2D = 7, PCSrcE = 0 -> StallF = StallD = FlushE = 1 for 1 cycle; stall_cnt increments by 1. Same with PCSrcE = 1 -> StallF = 0, FlushD = FlushE = 1.
- Memory wait: MemReqM = 1, dmem_ready low for 3 cycles then high -> all stalls and FlushW = 1 for exactly 3 cycles, state back to RUN, stall_cnt += 3.
- Timeout: MEM_TIMEOUT = 4, dmem_ready held 0 -> mem_timeout_err = 1 after the 5th stalled cycle, stalls stay high permanently. rst pulse clears everything.
- Branch under memory stall: PCSrcE = 1 and mem_stall together -> FlushD = FlushE = 0. On the first cycle after dmem_ready: FlushD = FlushE = 1, flush_cnt += 1.
- Saturation: XLEN_CNT = 4, 20 consecutive load-use stalls -> stall_cnt = 15, no wrap. Asynchronous rst mid-MEM_WAIT -> outputs return to reset values before the next clock edge.
